mem_access_ctrl: RTL and testbench

//  Upstream driver for the 256x16 data memory. Accepts one load/store request at a time from
//  the CPU control path over a valid/ready handshake and sequences address setup and strobes.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_wait_timer.sv | 40 ++++
 rtl/mem_access_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_pkg
//  Purpose : Shared definitions for the data-memory access controller:
//            default bus widths, implemented depth, index width and the
//            access state encoding.
//  Revision: 1.0  initial release
// ============================================================================
package mem_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_DEPTH  = 256;
  localparam int MEM_IDX_W  = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module  : mem_wait_timer
//  Purpose : Counts the cycles a memory strobe is held. Counts 0..COUNT-1
//            while enabled and flags done on the final strobe cycle.
//  Ports   : clock   in  system clock, rising edge
//            reset_n in  asynchronous active-low reset
//            load    in  restart the count at 0
//            en      in  advance the count (strobe phase)
//            done    out count has reached COUNT-1
//  Revision: 1.0  initial release
// ============================================================================
module mem_wait_timer #(
  parameter int COUNT = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int CNT_W = $clog2(COUNT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= '0;
    end else if (en && !done) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign done = (r_cnt == CNT_W'(COUNT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : mem_access_ctrl
//  Purpose : Sequences one load/store at a time into the 256x16 data memory:
//            IDLE -> SETUP (address settles) -> STROBE (READ_WAIT cycles)
//            -> RESP (held until accepted). Load data lands in the MDR.
//  Config  : MEM_ACCESS_BOUNDS_CHECK_EN - when defined, addresses >= DEPTH
//            skip the strobe and complete with fault=1; when undefined the
//            address wraps modulo DEPTH and fault is tied low.
//  Ports   : clock/reset_n          clock, async active-low reset
//            req_valid/req_ready    request handshake (ready only in IDLE)
//            req_write/addr/wdata   request contents
//            resp_valid/resp_ready  response handshake, held until accepted
//            resp_rdata             MDR contents
//            fault                  out-of-range access flag
//            mem_addr/mem_wdata     memory address / write data
//            mem_read/mem_write     memory strobes
//            mem_rdata              memory read data
//  Revision: 1.0  initial release
// ============================================================================
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int DEPTH     = MEM_DEPTH,
  parameter int READ_WAIT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_write;
  logic [DATA_W-1:0]   r_mdr;
  logic [ADDR_W-1:0]   w_addr_eff;
  logic                w_skip;
  logic                w_accept;
  logic                w_done;

  assign w_accept = req_valid && (r_state == ST_IDLE);

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  logic r_oob;
  logic r_fault;

  assign w_addr_eff = req_addr;
  assign w_skip     = r_oob;
  assign fault      = r_fault;

  // r_oob is classified at accept; fault is raised only for the RESP phase.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_oob   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_oob <= (req_addr >= ADDR_W'(DEPTH));
      end
      if (r_state == ST_SETUP && r_oob) begin
        r_fault <= 1'b1;
      end else if (r_state == ST_RESP && resp_ready) begin
        r_fault <= 1'b0;
      end
    end
  end
`else
  // Without range checking the upper address bits are discarded (wrap).
  assign w_addr_eff = req_addr % ADDR_W'(DEPTH);
  assign w_skip     = 1'b0;
  assign fault      = 1'b0;
`endif

  mem_wait_timer #(
    .COUNT (READ_WAIT)
  ) u_wait_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (r_state == ST_SETUP),
    .en      (r_state == ST_STROBE),
    .done    (w_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (req_valid)  w_next = ST_SETUP;
      ST_SETUP:  w_next = w_skip ? ST_RESP : ST_STROBE;
      ST_STROBE: if (w_done)     w_next = ST_RESP;
      ST_RESP:   if (resp_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Request registers feed the memory pins directly, so address/data are
  // already stable during SETUP and simply hold once the access ends.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_mdr   <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= w_addr_eff;
        r_wdata <= req_wdata;
        r_write <= req_write;
      end
      if (r_state == ST_STROBE && w_done && !r_write) begin
        r_mdr <= mem_rdata;
      end
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign mem_read   = (r_state == ST_STROBE) && !r_write;
  assign mem_write  = (r_state == ST_STROBE) &&  r_write;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign resp_rdata = r_mdr;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mem_access_ctrl
//  Purpose : Scoreboard bench for mem_access_ctrl with a behavioural memory
//            and a reference model of memory contents and the MDR.
//  Revision: 1.0  initial release
// ============================================================================
module tb_mem_access_ctrl;

  localparam int RW    = 3;
  localparam int DEPTH = 256;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_rdata;
  logic        fault;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  always #5 clock = ~clock;

  mem_access_ctrl #(
    .ADDR_W    (16),
    .DATA_W    (16),
    .DEPTH     (DEPTH),
    .READ_WAIT (RW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .fault      (fault),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_now();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out, got no event expected one (t=%0t)", name, $time);
    finish_now();
  endtask

  function automatic logic [15:0] init_val(input int i);
    if (i == 16) return 16'hBEEF;
    return 16'(i * 257) ^ 16'h5A5A;
  endfunction

  // Behavioural memory driven by the DUT strobes.
  logic [15:0] bmem [0:DEPTH-1];
  initial begin
    for (int i = 0; i < DEPTH; i++) bmem[i] = init_val(i);
    forever begin
      @(posedge clock);
      if (mem_write && mem_addr < 16'(DEPTH)) bmem[mem_addr[7:0]] = mem_wdata;
    end
  end
  assign mem_rdata = (mem_addr < 16'(DEPTH)) ? bmem[mem_addr[7:0]] : (mem_addr ^ 16'hDEAD);

  // Reference model state and scoreboard.
  typedef struct {
    logic [15:0] addr;
    logic        write;
    logic [15:0] rdata;
    logic        fault;
    int          accept_edge;
  } exp_t;

  exp_t        q[$];
  logic [15:0] ref_mem [0:DEPTH-1];
  logic [15:0] ref_mdr;

  // Response-ready driver: random backpressure or forced stall.
  bit bp_rand  = 1'b0;
  bit hold_low = 1'b0;
  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (hold_low)     resp_ready = 1'b0;
      else if (bp_rand) resp_ready = ($urandom_range(0, 3) != 0);
      else              resp_ready = 1'b1;
    end
  end

  // Monitor: strobe legality, response contents, latency, stability.
  initial begin
    int          rd_cyc = 0, wr_cyc = 0;
    bit          seen_first = 1'b0, prev_stall = 1'b0;
    logic [15:0] prev_rdata = '0;
    logic        prev_fault = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        rd_cyc = 0; wr_cyc = 0; seen_first = 1'b0; prev_stall = 1'b0;
        continue;
      end
      if (mem_read || mem_write) begin
        chk("strobe_exclusive", 32'(mem_read && mem_write), 32'd0);
        if (q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL strobe_unexpected: got strobe expected none (t=%0t)", $time);
        end else begin
          chk("strobe_addr", 32'(mem_addr), 32'(q[0].addr));
          if (q[0].write) chk("strobe_wdata", 32'(mem_wdata), 32'(ref_mem[q[0].addr[7:0]]));
        end
      end
      if (mem_read)  rd_cyc++;
      if (mem_write) wr_cyc++;
      if (prev_stall) begin
        chk("stall_valid_held", 32'(resp_valid), 32'd1);
        chk("stall_rdata_stable", 32'(resp_rdata), 32'(prev_rdata));
        chk("stall_fault_stable", 32'(fault), 32'(prev_fault));
      end
      if (resp_valid) begin
        if (q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL resp_unexpected: got resp_valid=1 expected 0 (t=%0t)", $time);
        end else begin
          if (!seen_first) begin
            chk("latency", 32'(cyc - q[0].accept_edge), q[0].fault ? 32'd1 : 32'(1 + RW));
            seen_first = 1'b1;
          end
          chk("resp_rdata", 32'(resp_rdata), 32'(q[0].rdata));
          chk("resp_fault", 32'(fault), 32'(q[0].fault));
          chk("req_ready_busy", 32'(req_ready), 32'd0);
          if (resp_ready) begin
            chk("read_strobe_cycles", 32'(rd_cyc),
                (!q[0].write && !q[0].fault) ? 32'(RW) : 32'd0);
            chk("write_strobe_cycles", 32'(wr_cyc),
                (q[0].write && !q[0].fault) ? 32'(RW) : 32'd0);
            void'(q.pop_front());
            rd_cyc = 0; wr_cyc = 0; seen_first = 1'b0;
          end
        end
      end
      prev_stall = resp_valid && !resp_ready;
      prev_rdata = resp_rdata;
      prev_fault = fault;
    end
  end

  // Issue one request starting at a negedge; returns at the negedge after
  // the accepting edge with req_valid still high (caller may hold or drop).
  task automatic issue(input logic [15:0] a, input logic w, input logic [15:0] d,
                       output int acc_edge);
    int   waited = 0;
    exp_t e;
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = d;
    while (!req_ready) begin
      @(negedge clock);
      waited++;
      if (waited > 200) timeout("req_accept");
    end
    acc_edge = cyc + 1;
    e.accept_edge = acc_edge;
    e.write       = w;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    e.fault = (int'(a) >= DEPTH);
    e.addr  = a;
`else
    e.fault = 1'b0;
    e.addr  = 16'(int'(a) % DEPTH);
`endif
    if (!e.fault) begin
      if (w) ref_mem[int'(a) % DEPTH] = d;
      else   ref_mdr = ref_mem[int'(a) % DEPTH];
    end
    e.rdata = ref_mdr;
    q.push_back(e);
    @(negedge clock);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    while (q.size() != 0) begin
      @(negedge clock);
      n++;
      if (n > 500) timeout("drain");
    end
    @(negedge clock);
  endtask

  initial begin
    #500000;
    timeout("watchdog");
  end

  initial begin
    int          acc, e0, e1, e2, n;
    logic [15:0] a;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    ref_mdr = '0;

    repeat (3) @(negedge clock);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_fault",      32'(fault),      32'd0);
    chk("rst_mem_read",   32'(mem_read),   32'd0);
    chk("rst_mem_write",  32'(mem_write),  32'd0);
    chk("rst_mem_addr",   32'(mem_addr),   32'd0);
    chk("rst_mem_wdata",  32'(mem_wdata),  32'd0);
    chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Directed: preloaded word, store/load pair, out-of-range address.
    issue(16'h0010, 1'b0, 16'h0000, acc);
    drain();
    issue(16'h0020, 1'b1, 16'h1234, acc);
    issue(16'h0020, 1'b0, 16'hFFFF, acc);
    drain();
    issue(16'h0105, 1'b0, 16'h0000, acc);
    drain();

    // Held response for 5 cycles.
    hold_low = 1'b1;
    issue(16'h0007, 1'b0, 16'h0000, acc);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid) begin
      @(negedge clock);
      n++;
      if (n > 50) timeout("bp_resp_valid");
    end
    repeat (5) begin
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clock);
    end
    hold_low = 1'b0;
    drain();

    // Back-to-back with req_valid held.
    issue(16'h0003, 1'b0, 16'h0000, e0);
    issue(16'h0004, 1'b1, 16'hA5A5, e1);
    issue(16'h0004, 1'b0, 16'h0000, e2);
    chk("b2b_gap1", 32'(e1 - e0), 32'(RW + 3));
    chk("b2b_gap2", 32'(e2 - e1), 32'(RW + 3));
    drain();

    // Randomized traffic with random backpressure.
    bp_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clock);
      end
      if ($urandom_range(0, 4) == 0) a = 16'($urandom);
      else                           a = 16'($urandom_range(0, 31));
      issue(a, 1'($urandom_range(0, 1)), 16'($urandom), acc);
    end
    drain();
    bp_rand = 1'b0;

    // Reset during the strobe phase.
    issue(16'h0030, 1'b0, 16'h0000, acc);
    req_valid = 1'b0;
    n = 0;
    while (!mem_read) begin
      @(negedge clock);
      n++;
      if (n > 50) timeout("mid_reset_strobe");
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_mem_read",   32'(mem_read),   32'd0);
    chk("midrst_mem_write",  32'(mem_write),  32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_resp_rdata", 32'(resp_rdata), 32'd0);
    q.delete();
    ref_mdr = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clock);
      chk("postrst_resp_valid", 32'(resp_valid), 32'd0);
      chk("postrst_req_ready",  32'(req_ready),  32'd1);
    end
    issue(16'h0030, 1'b0, 16'h0000, acc);
    drain();

    finish_now();
  end

endmodule
`default_nettype wire
